// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-frame debounce.
// Drives one row low at a time for SCAN_DIV clocks and samples the active-low
// columns at the end of each row slot. Each completed 16-key frame is decoded
// to a single key, no key, or invalid (ghost or multi-press). A key that stays
// stable for DEBOUNCE_CNT frames is accepted one clock after the frame completes.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   col_in     keypad columns, active-low (already synchronous)
//   key_ack    consumer acknowledge pulse; clears key_valid
//   row_out    keypad rows, active-low, one-hot-low
//   key_code   last accepted key, row*4+col
//   key_valid  set on press acceptance, cleared by key_ack
//   key_down   debounced "key held" level
//   overrun    (only with KEYPAD_OVERRUN_EN) sticky flag: a press arrived
//              while an unacknowledged key was pending; cleared by key_ack
//
// Optional feature macro: KEYPAD_OVERRUN_EN
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
`ifdef KEYPAD_OVERRUN_EN
  output logic       overrun,
`endif
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);

  // Candidate encoding: 0..15 are key codes, plus two out-of-band values.
  localparam logic [4:0] CAND_NONE    = 5'd16;
  localparam logic [4:0] CAND_INVALID = 5'd17;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic [15:0]   snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    prev_q, prev_d;
  logic [4:0]    deb_q, deb_d;
  logic          pend_press_q, pend_press_d;
  logic          pend_rel_q, pend_rel_d;
  logic [3:0]    pend_key_q, pend_key_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          ovr_q, ovr_d;

  logic          sample_now;
  logic          frame_done;
  logic [15:0]   frame_vec;
  logic [4:0]    low_cnt;
  logic [3:0]    low_idx;
  logic [4:0]    cand;

  always_comb begin
    // Defaults: hold everything, no pending actions.
    div_d        = div_q;
    row_d        = row_q;
    snap_d       = snap_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    deb_d        = deb_q;
    pend_press_d = 1'b0;
    pend_rel_d   = 1'b0;
    pend_key_d   = pend_key_q;
    key_code_d   = key_code_q;
    key_valid_d  = key_valid_q;
    key_down_d   = key_down_q;
    ovr_d        = ovr_q;
    low_cnt      = 5'd0;
    low_idx      = 4'd0;
    cand         = CAND_NONE;

    sample_now = (div_q == DIV_LAST);
    frame_done = sample_now && (row_q == 2'd3);

    // Row scan and per-row column capture.
    if (sample_now) begin
      div_d = '0;
      row_d = row_q + 2'd1;
      snap_d[{row_q, 2'b00} +: 4] = col_in;
    end else begin
      div_d = div_q + DW'(1);
    end

    // Frame decode uses the live row-3 columns, since they land in the
    // snapshot on this same edge.
    frame_vec = {col_in, snap_q[11:0]};
    for (int i = 0; i < 16; i++) begin
      if (!frame_vec[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    if (low_cnt == 5'd0)      cand = CAND_NONE;
    else if (low_cnt == 5'd1) cand = {1'b0, low_idx};
    else                      cand = CAND_INVALID;

    if (frame_done) begin
      prev_d = cand;
      if (cand == CAND_INVALID)                cnt_d = '0;
      else if (cand == prev_q)                 cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      else                                     cnt_d = CW'(1);

      // Decision is registered and applied on the following edge.
      if ((cnt_d == CNT_MAX) && (cand != CAND_INVALID)) begin
        if (cand == CAND_NONE) begin
          pend_rel_d = 1'b1;
        end else if (cand != deb_q) begin
          pend_press_d = 1'b1;
          pend_key_d   = cand[3:0];
        end
      end
    end

    // Ack first, so a press on the same edge overrides it.
    if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
      ovr_d       = 1'b0;
    end else if (pend_press_q && key_valid_q) begin
      ovr_d = 1'b1;
    end

    if (pend_press_q) begin
      key_code_d  = pend_key_q;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      deb_d       = {1'b0, pend_key_q};
    end else if (pend_rel_q) begin
      key_down_d = 1'b0;
      deb_d      = CAND_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      row_q        <= 2'd0;
      snap_q       <= 16'h0000;
      cnt_q        <= '0;
      prev_q       <= CAND_NONE;
      deb_q        <= CAND_NONE;
      pend_press_q <= 1'b0;
      pend_rel_q   <= 1'b0;
      pend_key_q   <= 4'd0;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      key_down_q   <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      div_q        <= div_d;
      row_q        <= row_d;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      deb_q        <= deb_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      pend_key_q   <= pend_key_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_down_q   <= key_down_d;
      ovr_q        <= ovr_d;
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
`ifdef KEYPAD_OVERRUN_EN
  assign overrun   = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_q;
`endif

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad by driving one row low at a time and reading the active-low column lines.
- Debounces whole-frame results and presents a 4-bit hex key code with a valid/ack handshake.
- It is the input-side counterpart of the multiplexed seven-segment display scanner. Key codes feed the number-entry logic and the ALU operands in place of the discrete push-buttons.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven; legal range >= 2.
- DEBOUNCE_CNT, 4: consecutive identical frames required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- col_in  input  4  keypad columns, active-low, externally pulled up; treated as already synchronous.
- key_ack  input  1  consumer pulse; clears key_valid.
- row_out  output  4  keypad rows, active-low, exactly one bit low at any time.
- key_code  output  4  code of the last accepted key, row*4+col.
- key_valid  output  1  high from press acceptance until key_ack.
- key_down  output  1  debounced "a key is held" level.

Behaviour:
- Reset (async, immediate):
  - row_out=4'b1110, key_code=0, key_valid=0, key_down=0.
  - Divider=0, row index=0, frame snapshot=0, stable count=0, debounced candidate=NONE.
- Divider counts 0..SCAN_DIV-1.
  - At terminal count: col_in is sampled into the snapshot slot for the current row, the divider wraps to 0, and the row index advances 0->1->2->3->0.
  - row_out = ~(1<<row).
- Frame = 4*SCAN_DIV cycles. A frame completes at the row-3 sample.
- Frame decode, using the row-3 sample taken that cycle:
  - Exactly one low bit in the 16-bit snapshot: candidate = row*4 + col.
  - Zero low bits: candidate = NONE.
  - Two or more low bits (ghosting or multi-press): candidate = INVALID. INVALID never produces a press, resets the stable count to 0, and leaves key_down unchanged.
- Stable count, updated only at frame completion:
  - If the candidate equals the previous frame's candidate, increment, saturating at DEBOUNCE_CNT.
  - Otherwise load 1 (load 0 for INVALID).
- Press: when the stable count becomes DEBOUNCE_CNT with candidate = key K, and the debounced state is not already K:
  - Next edge: key_code<=K, key_valid<=1, key_down<=1, debounced state<=K.
- Release: when the stable count becomes DEBOUNCE_CNT with candidate NONE:
  - Next edge: key_down<=0, debounced state<=NONE. key_valid is unaffected.
- Direct change from key A to key B (no NONE frames between) is accepted as a new press of B once B is stable.
- Holding a key produces exactly one press. No auto-repeat.
- Handshake:
  - key_ack while key_valid=1 clears key_valid next edge.
  - key_ack while key_valid=0 is ignored.
  - Ack and a new press in the same cycle: the press wins; key_valid stays 1 and key_code updates.
  - A press while key_valid=1 and no ack: key_code is overwritten with the newest key.
- Latency: key_valid rises one edge after the row-3 sample that completes the DEBOUNCE_CNT-th consecutive matching frame.
- Reset mid-frame or mid-debounce discards the snapshot and count. A key held through reset must be re-debounced from frame 1.

Optional Feature:
- Macro KEYPAD_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, reset 0).
  - Set when a press is accepted while key_valid=1 and key_ack is not asserted that cycle.
  - Sticky; cleared only by a key_ack (the same edge that clears key_valid). If a new press is accepted on that same ack edge, key_valid stays 1 per the press-wins rule and overrun still clears.
  - key_code behaviour is unchanged (newest wins).
- Undefined: port absent; overwrite is silent.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, col_in=4'hF -> row_out cycles 1110,1101,1011,0111 every 4 clks. key_valid, key_down and key_code stay 0.
- Hold key row 2/col 1 (col_in bit1 low only while row_out=1011) from frame start -> key_code=4'h9, key_valid=1, key_down=1, one edge after the third frame's row-3 sample. Exactly one press while held.
- After a press, pulse key_ack -> key_valid=0 next edge. Release the key for 3 frames -> key_down=0, no new key_valid.
- Bounce: key 5 present 2 frames, absent 1 frame, present 3 frames -> single press, accepted only after the final 3-frame run.
- Keys 0 and 6 held together -> INVALID, no press, key_down unchanged. Release 6 -> press of 0 after 3 frames.
- Press 3, no ack, then press C -> key_code=4'hC, key_valid=1, overrun=1 (with KEYPAD_OVERRUN_EN). key_ack -> key_valid=0, overrun=0. Assert rst mid-frame -> all outputs reset immediately.
